// File: rtl/change_checker.sv
`default_nettype none
// ============================================================================
// Module      : change_checker
// Description : Checks a sampled signal against a selectable temporal property
//               (changed / stable / rose / fell) versus its value DEPTH samples
//               earlier, with warm-up, failure counting and optional halt.
// Revision    : 1.0 - initial release
// ============================================================================
module change_checker #(
  parameter int WIDTH        = 1,
  parameter int DEPTH        = 1,
  parameter int SKIP         = 1,
  parameter int CNT_W        = 8,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] val,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic [WIDTH-1:0] cur_val,
  output logic [WIDTH-1:0] past_val,
  output logic             changed,
  output logic             stable,
  output logic             rose,
  output logic             fell,
  output logic             armed,
  output logic             fail,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             sticky_err,
  output logic             halted
);

  localparam int         c_THRESH = (SKIP > DEPTH) ? SKIP : DEPTH;
  localparam logic [1:0] c_WARMUP = 2'd0;
  localparam logic [1:0] c_ARMED  = 2'd1;
  localparam logic [1:0] c_HALT   = 2'd2;

  logic [WIDTH-1:0] r_hist [0:DEPTH];
  logic [1:0]       r_state;
  logic [7:0]       r_warm_cnt;
  logic             r_fail;
  logic [CNT_W-1:0] r_fail_cnt;
  logic             r_sticky;

  logic [WIDTH-1:0] w_nxt_past;
  logic             w_flag_sel;
  logic             w_check_fail;
  logic             w_warm_done;

  // The incoming sample is judged against the entry that becomes past_val on
  // this same edge, so fail lines up with the status flags it refers to.
  assign w_nxt_past = r_hist[DEPTH-1];

  always_comb begin
    w_flag_sel = 1'b0;
    case (mode)
      2'b00:   w_flag_sel = (val != w_nxt_past);
      2'b01:   w_flag_sel = (val == w_nxt_past);
      2'b10:   w_flag_sel = !w_nxt_past[0] && val[0];
      default: w_flag_sel = w_nxt_past[0] && !val[0];
    endcase
  end

  assign w_check_fail = (r_state == c_ARMED) && en && !w_flag_sel;
  assign w_warm_done  = ({1'b0, r_warm_cnt} + 9'd1) >= 9'(c_THRESH);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= DEPTH; i++) r_hist[i] <= '0;
    end else begin
      r_hist[0] <= val;
      for (int i = 1; i <= DEPTH; i++) r_hist[i] <= r_hist[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_state    <= c_WARMUP;
      r_warm_cnt <= '0;
      r_fail     <= 1'b0;
      r_fail_cnt <= '0;
      r_sticky   <= 1'b0;
    end else begin
      r_fail <= w_check_fail;
      case (r_state)
        c_WARMUP: begin
          r_warm_cnt <= r_warm_cnt + 8'd1;
          if (w_warm_done) r_state <= c_ARMED;
        end
        c_ARMED: begin
          if (w_check_fail) begin
            if (!(&r_fail_cnt)) r_fail_cnt <= r_fail_cnt + 1'b1;
            r_sticky <= 1'b1;
            if (STOP_ON_FAIL != 0) r_state <= c_HALT;
          end
        end
        c_HALT:  r_state <= c_HALT;
        default: r_state <= c_WARMUP;
      endcase
    end
  end

  assign cur_val    = r_hist[0];
  assign past_val   = r_hist[DEPTH];
  assign changed    = (r_hist[0] != r_hist[DEPTH]);
  assign stable     = !changed;
  assign rose       = !r_hist[DEPTH][0] && r_hist[0][0];
  assign fell       = r_hist[DEPTH][0] && !r_hist[0][0];
  assign armed      = (r_state == c_ARMED);
  assign halted     = (r_state == c_HALT);
  assign fail       = r_fail;
  assign fail_cnt   = r_fail_cnt;
  assign sticky_err = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_change_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_change_checker
// Description : Scoreboard bench for change_checker; two parameterisations
//               driven together and compared against a sample-list model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_change_checker;

  typedef struct packed {
    logic [3:0] cur;
    logic [3:0] past;
    logic       ch;
    logic       st;
    logic       ro;
    logic       fe;
    logic       arm;
    logic       fl;
    logic [7:0] cnt;
    logic       stk;
    logic       hlt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] val4 = 4'h0;

  logic [0:0] cur_a, past_a;
  logic       ch_a, st_a, ro_a, fe_a, arm_a, fl_a, stk_a, hlt_a;
  logic [7:0] cnt_a;
  logic [3:0] cur_b, past_b;
  logic       ch_b, st_b, ro_b, fe_b, arm_b, fl_b, stk_b, hlt_b;
  logic [3:0] cnt_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  change_checker #(.WIDTH(1), .DEPTH(1), .SKIP(1), .CNT_W(8), .STOP_ON_FAIL(1)) u_a (
    .clk(clk), .rst(rst), .val(val4[0]), .en(en), .mode(mode), .clr(clr),
    .cur_val(cur_a), .past_val(past_a), .changed(ch_a), .stable(st_a),
    .rose(ro_a), .fell(fe_a), .armed(arm_a), .fail(fl_a), .fail_cnt(cnt_a),
    .sticky_err(stk_a), .halted(hlt_a));

  change_checker #(.WIDTH(4), .DEPTH(3), .SKIP(5), .CNT_W(4), .STOP_ON_FAIL(0)) u_b (
    .clk(clk), .rst(rst), .val(val4), .en(en), .mode(mode), .clr(clr),
    .cur_val(cur_b), .past_val(past_b), .changed(ch_b), .stable(st_b),
    .rose(ro_b), .fell(fe_b), .armed(arm_b), .fail(fl_b), .fail_cnt(cnt_b),
    .sticky_err(stk_b), .halted(hlt_b));

  // Reference: per instance, the list of samples since reset (newest first),
  // edges seen since the last rst/clr, and the failure bookkeeping.
  int         dep [2]  = '{1, 3};
  int         thr [2]  = '{1, 5};
  int         stop [2] = '{1, 0};
  int         cmax [2] = '{255, 15};
  logic [3:0] wmask [2] = '{4'h1, 4'hF};
  logic [3:0] mh [2][0:8];
  int         mn [2];
  bit         mhalt [2];
  int         mcnt [2];
  bit         mstk [2];
  bit         mfail [2];
  exp_t       q0 [$];
  exp_t       q1 [$];

  task automatic model_edge(input int k, input bit r, input bit c,
                            input logic [3:0] v, input bit e, input logic [1:0] m);
    bit         was_armed;
    bit         flag;
    bit         failing;
    logic [3:0] cu;
    logic [3:0] pa;
    exp_t       x;
    if (r) begin
      for (int i = 0; i <= 8; i++) mh[k][i] = 4'h0;
      mn[k] = 0; mhalt[k] = 0; mcnt[k] = 0; mstk[k] = 0; mfail[k] = 0;
    end else begin
      was_armed = !mhalt[k] && (mn[k] >= thr[k]);
      for (int i = 8; i > 0; i--) mh[k][i] = mh[k][i-1];
      mh[k][0] = v & wmask[k];
      cu = mh[k][0];
      pa = mh[k][dep[k]];
      case (m)
        2'd0:    flag = (cu != pa);
        2'd1:    flag = (cu == pa);
        2'd2:    flag = !pa[0] && cu[0];
        default: flag = pa[0] && !cu[0];
      endcase
      failing = was_armed && e && !flag;
      if (c) begin
        mn[k] = 0; mhalt[k] = 0; mcnt[k] = 0; mstk[k] = 0; mfail[k] = 0;
      end else begin
        mfail[k] = failing;
        if (failing) begin
          if (mcnt[k] < cmax[k]) mcnt[k] = mcnt[k] + 1;
          mstk[k] = 1;
          if (stop[k] != 0) mhalt[k] = 1;
        end
        if (mn[k] < 1000) mn[k] = mn[k] + 1;
      end
    end
    cu = mh[k][0];
    pa = mh[k][dep[k]];
    x.cur  = cu;
    x.past = pa;
    x.ch   = (cu != pa);
    x.st   = (cu == pa);
    x.ro   = !pa[0] && cu[0];
    x.fe   = pa[0] && !cu[0];
    x.arm  = !mhalt[k] && (mn[k] >= thr[k]);
    x.fl   = mfail[k];
    x.cnt  = 8'(mcnt[k]);
    x.stk  = mstk[k];
    x.hlt  = mhalt[k];
    if (k == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  task automatic step(input bit r, input bit c, input logic [3:0] v,
                      input bit e, input logic [1:0] m);
    rst = r; clr = c; val4 = v; en = e; mode = m;
    @(posedge clk);
    model_edge(0, r, c, v, e, m);
    model_edge(1, r, c, v, e, m);
    #1;
  endtask

  task automatic cmp(input string nm, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual cur=%h past=%h ch/st/ro/fe=%b%b%b%b arm=%b fail=%b cnt=%0d stk=%b hlt=%b | required cur=%h past=%h ch/st/ro/fe=%b%b%b%b arm=%b fail=%b cnt=%0d stk=%b hlt=%b",
               nm, $time, act.cur, act.past, act.ch, act.st, act.ro, act.fe, act.arm, act.fl, act.cnt, act.stk, act.hlt,
               exp.cur, exp.past, exp.ch, exp.st, exp.ro, exp.fe, exp.arm, exp.fl, exp.cnt, exp.stk, exp.hlt);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
    end
  endtask

  // Monitor: every cycle each instance presents a full output set to score.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        a = {3'b000, cur_a, 3'b000, past_a, ch_a, st_a, ro_a, fe_a, arm_a, fl_a, cnt_a, stk_a, hlt_a};
        cmp("dutA", a, e);
      end
      if (q1.size() != 0) begin
        e = q1.pop_front();
        a = {cur_b, past_b, ch_b, st_b, ro_b, fe_b, arm_b, fl_b, 4'h0, cnt_b, stk_b, hlt_b};
        cmp("dutB", a, e);
      end
    end
  end

  initial begin
    logic [3:0] pv;
    logic [3:0] pat;
    pv = 4'h0;

    step(1, 0, 4'h0, 0, 2'd0);
    step(1, 0, 4'h0, 0, 2'd0);
    chk("reset_stable_a", int'(st_a), 1);
    chk("reset_armed_a", int'(arm_a), 0);
    chk("reset_cnt_b", int'(cnt_b), 0);

    // Toggling with mode "changed": no failure expected anywhere.
    for (int i = 0; i < 20; i++) begin
      pv = ~pv;
      step(0, 0, pv, 1, 2'd0);
    end
    chk("toggle_armed_a", int'(arm_a), 1);
    chk("toggle_cnt_a", int'(cnt_a), 0);
    chk("toggle_cnt_b", int'(cnt_b), 0);

    // One held sample: a single failure, A halts.
    step(0, 0, pv, 1, 2'd0);
    chk("hold_fail_a", int'(fl_a), 1);
    for (int i = 0; i < 5; i++) begin
      pv = ~pv;
      step(0, 0, pv, 1, 2'd0);
    end
    chk("hold_cnt_a", int'(cnt_a), 1);
    chk("hold_sticky_a", int'(stk_a), 1);
    chk("hold_halted_a", int'(hlt_a), 1);
    chk("hold_fail_cleared_a", int'(fl_a), 0);

    // Constant signal: B (no halt) saturates its 4-bit counter.
    step(0, 1, pv, 1, 2'd0);
    for (int i = 0; i < 40; i++) step(0, 0, pv, 1, 2'd0);
    chk("sat_cnt_b", int'(cnt_b), 15);
    chk("sat_armed_b", int'(arm_b), 1);

    // Period-3 pattern is stable at distance 3.
    step(0, 1, pv, 0, 2'd1);
    pat = 4'b0110;
    for (int i = 0; i < 30; i++) begin
      step(0, 0, (pat[i % 3] ? 4'hF : 4'h0), 1, 2'd1);
    end
    chk("period3_cnt_b", int'(cnt_b), 0);

    // clr on the same edge as a failing check wins.
    step(1, 0, 4'h0, 0, 2'd2);
    for (int i = 0; i < 6; i++) step(0, 0, 4'h0, 0, 2'd2);
    step(0, 1, 4'h0, 1, 2'd2);
    chk("clrwin_fail_a", int'(fl_a), 0);
    chk("clrwin_cnt_a", int'(cnt_a), 0);
    chk("clrwin_armed_a", int'(arm_a), 0);
    chk("clrwin_fail_b", int'(fl_b), 0);

    // Reset while halted, then re-arm.
    step(0, 0, 4'h0, 1, 2'd2);
    step(0, 0, 4'h0, 1, 2'd2);
    chk("pre_rst_halted_a", int'(hlt_a), 1);
    step(1, 0, 4'h0, 1, 2'd2);
    chk("rst_halted_a", int'(hlt_a), 0);
    chk("rst_cnt_a", int'(cnt_a), 0);
    for (int i = 0; i < 6; i++) step(0, 0, 4'($urandom), 0, 2'd0);
    chk("rearm_a", int'(arm_a), 1);
    chk("rearm_b", int'(arm_b), 1);

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      bit r;
      bit c;
      r = ($urandom_range(0, 99) == 0);
      c = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 1) pv = 4'($urandom);
      step(r, c, pv, ($urandom_range(0, 4) != 0), 2'($urandom));
    end

    step(0, 0, pv, 0, 2'd0);
    @(negedge clk);
    #1;
    chk("queue_drained_a", q0.size(), 0);
    chk("queue_drained_b", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
